argon_bus_sequencer: RTL and testbench
======================================

Name: argon_bus_sequencer

Overview:
- Control unit for the shared Argon unit bus. It takes over driving write_id, write_command, read_id and read_command, which the bench currently drives by hand.
- Queues bus-transfer micro-ops from the decoder: source unit/command, destination unit/command and a tag.
- Issues one micro-op at a time and waits for the source's bus valid, with a timeout.
- Reports each completion with its tag and an error flag.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TAG_W, 4, width of the request/completion tag.
- TIMEOUT, 15, maximum wait cycles in XFER for i_bus_valid before abort; ≥1, <256.

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request offered
- o_req_ready  out  1  request accepted when valid&ready
- i_req_src_id  in  4  unit that writes the bus (ID_NONE = none)
- i_req_src_cmd  in  4  write_command for the source
- i_req_dst_id  in  4  unit that reads the bus (ID_NONE = none)
- i_req_dst_cmd  in  4  read_command for the destination
- i_req_tag  in  TAG_W  opaque tag, returned on completion
- i_abort  in  1  flush FIFO and kill the in-flight transfer
- i_bus_valid  in  1  master bus o_valid (the source is driving data)
- o_write_id  out  4  bus write_id
- o_write_command  out  4  bus write_command
- o_read_id  out  4  bus read_id
- o_read_command  out  4  bus read_command
- o_done_valid  out  1  one-cycle completion pulse
- o_done_tag  out  TAG_W  tag of the completed op
- o_done_error  out  1  op timed out or was aborted
- o_busy  out  1  FIFO non-empty or state≠IDLE

Behaviour:
- Reset (synchronous, active-high; in force while i_Reset high):
  - o_write_id = o_read_id = ID_NONE; commands 0.
  - o_done_valid = 0, o_done_tag = 0, o_done_error = 0.
  - FIFO empty, state IDLE, wait counter 0.
- o_req_ready = !full & !i_Reset & !i_abort. No push-through when full.
- States:
  - IDLE: bus outputs ID_NONE/0. If FIFO non-empty, pop the head into the op register and go to XFER. The first bus drive is therefore the cycle after the push (1-cycle latency).
  - XFER: bus outputs driven from the op register (src→write fields, dst→read fields). Completion occurs this cycle if:
    - src_id==ID_NONE (command-only to dst), or
    - dst_id==ID_NONE (command-only to src), or
    - i_bus_valid==1 (dst captures on this edge).
  - XFER, no completion and counter==TIMEOUT: abort the op, set error=1, count timeout.
  - XFER, otherwise: increment counter and hold.
- After completion or timeout:
  - Counter clears.
  - Next cycle: o_done_valid=1 with that op's tag and error.
  - If FIFO non-empty, pop the next op and stay in XFER (back-to-back: one transfer per cycle with immediate valid). Otherwise go to IDLE.
- Both src and dst ID_NONE: completes in 1 cycle, bus idle, error=0.
- i_abort:
  - FIFO cleared that edge; any push in the same cycle is refused.
  - If in XFER: next cycle go to IDLE with outputs ID_NONE, and o_done_valid=1, error=1 for the killed op.
  - Abort has priority over completion in the same cycle (reported as error).
- Reset mid-XFER: op dropped, no completion pulse.
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
- Counter width: clog2(TIMEOUT+1).

Optional Feature:
- Macro ARGON_BUS_SEQ_PERF_EN.
- When defined, adds outputs:
  - o_perf_xfers[15:0]: completions with error=0.
  - o_perf_stalls[15:0]: XFER cycles without completion.
  - o_perf_timeouts[7:0]: timeouts only.
- Counters saturate and clear on reset.
- When undefined, these ports and their logic are absent; functional behaviour is identical.

Decomposition:
- bus_seq_pkg holds:
  - ID_NONE = 4'hF (must not collide with any ID_* code in constants_pkg);
  - bus_seq_req_t packed struct {src_id, src_cmd, dst_id, dst_cmd, tag};
  - state enum {IDLE, XFER}.
- One sub-module: argon_sync_fifo.
  - Parameterised width/depth, synchronous reset.
  - Outputs full/empty and head data with show-ahead.
  - Instantiated with width $bits(bus_seq_req_t).

Test Plan:
1. Push {src=ID_REGFILE, cmd=2, dst=ID_ALU, cmd=1, tag=3}, bus_valid high in XFER → cycle+1 bus fields set; cycle+2 done_valid=1, tag=3, error=0.
2. Push 4 ops back-to-back, bus_valid constantly 1 → ready drops only if full; bus fields change every cycle; 4 done pulses on consecutive cycles with tags in order.
3. Op with bus_valid held 0, TIMEOUT=15 → fields held 16 cycles; then done tag, error=1; bus returns ID_NONE.
4. Op dst=ID_NONE (ALU command-only) → completes in 1 XFER cycle regardless of bus_valid, error=0.
5. 3 ops queued, i_abort in 2nd cycle of first XFER → one done with error=1; FIFO empty; o_busy=0 two cycles later; no further bus drive.
6. Reset asserted mid-XFER with 2 queued → next cycle all outputs at reset values, no done pulse, ready=1 after reset deasserts.

Source files
------------

// File: rtl/argon_bus_sequencer_pkg.sv
// Shared types and constants for the Argon bus sequencer.
package bus_seq_pkg;

  // Reserved "no unit" code. No real unit may use this value.
  localparam logic [3:0] ID_NONE = 4'hF;

  // Tag width carried through the request FIFO. The sequencer's TAG_W must match.
  localparam int REQ_TAG_W = 4;
  typedef logic [REQ_TAG_W-1:0] req_tag_t;

  typedef struct packed {
    logic [3:0] src_id;
    logic [3:0] src_cmd;
    logic [3:0] dst_id;
    logic [3:0] dst_cmd;
    req_tag_t   tag;
  } bus_seq_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } bus_seq_state_e;

  // Saturating increments used by the optional performance counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/argon_bus_sequencer_if.sv
// Request, abort, bus-control and completion signals of the Argon bus sequencer.
interface argon_bus_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [3:0]       i_req_src_id;
  logic [3:0]       i_req_src_cmd;
  logic [3:0]       i_req_dst_id;
  logic [3:0]       i_req_dst_cmd;
  logic [TAG_W-1:0] i_req_tag;
  logic             i_abort;
  logic             i_bus_valid;
  logic [3:0]       o_write_id;
  logic [3:0]       o_write_command;
  logic [3:0]       o_read_id;
  logic [3:0]       o_read_command;
  logic             o_done_valid;
  logic [TAG_W-1:0] o_done_tag;
  logic             o_done_error;
  logic             o_busy;

  // Sequencer side
  modport slave (
    input  i_req_valid, i_req_src_id, i_req_src_cmd, i_req_dst_id, i_req_dst_cmd,
           i_req_tag, i_abort, i_bus_valid,
    output o_req_ready, o_write_id, o_write_command, o_read_id, o_read_command,
           o_done_valid, o_done_tag, o_done_error, o_busy
  );

  // Decoder / environment side
  modport master (
    output i_req_valid, i_req_src_id, i_req_src_cmd, i_req_dst_id, i_req_dst_cmd,
           i_req_tag, i_abort, i_bus_valid,
    input  o_req_ready, o_write_id, o_write_command, o_read_id, o_read_command,
           o_done_valid, o_done_tag, o_done_error, o_busy
  );
endinterface

// File: rtl/argon_sync_fifo.sv
// Synchronous show-ahead FIFO with flush. DEPTH must be a power of 2.
module argon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == FULL_CNT);
  assign o_empty = (cnt_q == '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  // Pointer and occupancy update; flush wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents are only visible through valid pointers, so no reset
  always_ff @(posedge i_Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/argon_bus_sequencer.sv
// Argon bus sequencer: queues bus-transfer micro-ops, drives write/read id and
// command one op at a time, waits for the source's bus valid with a timeout and
// reports each completion with its tag and an error flag.
// Optional feature macro: ARGON_BUS_SEQ_PERF_EN (adds saturating perf counters).
module argon_bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  argon_bus_sequencer_if.slave   bus_if
`ifdef ARGON_BUS_SEQ_PERF_EN
  ,
  output logic [15:0]            o_perf_xfers,
  output logic [15:0]            o_perf_stalls,
  output logic [7:0]             o_perf_timeouts
`endif
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  bus_seq_state_e   state_q, state_d;
  bus_seq_req_t     op_q, op_d, fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_valid_q, done_valid_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic             done_error_q, done_error_d;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic             req_ready, xfer_complete, xfer_timeout;

  assign req_ready          = !fifo_full && !i_Reset && !bus_if.i_abort;
  assign fifo_push          = bus_if.i_req_valid && req_ready;
  assign fifo_wdata.src_id  = bus_if.i_req_src_id;
  assign fifo_wdata.src_cmd = bus_if.i_req_src_cmd;
  assign fifo_wdata.dst_id  = bus_if.i_req_dst_id;
  assign fifo_wdata.dst_cmd = bus_if.i_req_dst_cmd;
  assign fifo_wdata.tag     = req_tag_t'(bus_if.i_req_tag);

  argon_sync_fifo #(
    .WIDTH ($bits(bus_seq_req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_flush (fifo_flush),
    .i_push  (fifo_push),
    .i_data  (fifo_wdata),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Transfer end conditions: command-only ops finish at once, otherwise wait for valid
  always_comb begin
    xfer_complete = 1'b0;
    xfer_timeout  = 1'b0;
    if (state_q == XFER) begin
      xfer_complete = (op_q.src_id == ID_NONE) || (op_q.dst_id == ID_NONE) ||
                      bus_if.i_bus_valid;
      xfer_timeout  = !xfer_complete && (cnt_q == CNT_MAX);
    end
  end

  // Next-state: abort beats completion; a finished op hands over to the FIFO head
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    done_error_d = done_error_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    if (bus_if.i_abort) begin
      fifo_flush = 1'b1;
      cnt_d      = '0;
      if (state_q == XFER) begin
        state_d      = IDLE;
        done_valid_d = 1'b1;
        done_tag_d   = TAG_W'(op_q.tag);
        done_error_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            op_d     = fifo_rdata;
            cnt_d    = '0;
            state_d  = XFER;
          end
        end
        XFER: begin
          if (xfer_complete || xfer_timeout) begin
            done_valid_d = 1'b1;
            done_tag_d   = TAG_W'(op_q.tag);
            done_error_d = xfer_timeout;
            cnt_d        = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              op_d     = fifo_rdata;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and completion report
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      done_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      done_error_q <= done_error_d;
    end
  end

  // Op register; only read while in XFER, so it needs no reset
  always_ff @(posedge i_Clk) begin
    op_q <= op_d;
  end

  // Outputs: bus fields follow the op register only while transferring
  always_comb begin
    bus_if.o_write_id      = ID_NONE;
    bus_if.o_write_command = 4'h0;
    bus_if.o_read_id       = ID_NONE;
    bus_if.o_read_command  = 4'h0;
    if (state_q == XFER) begin
      bus_if.o_write_id      = op_q.src_id;
      bus_if.o_write_command = op_q.src_cmd;
      bus_if.o_read_id       = op_q.dst_id;
      bus_if.o_read_command  = op_q.dst_cmd;
    end
    bus_if.o_req_ready  = req_ready;
    bus_if.o_done_valid = done_valid_q;
    bus_if.o_done_tag   = done_tag_q;
    bus_if.o_done_error = done_error_q;
    bus_if.o_busy       = !fifo_empty || (state_q != IDLE);
  end

`ifdef ARGON_BUS_SEQ_PERF_EN
  logic [15:0] perf_xfers_q, perf_xfers_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;
  logic [7:0]  perf_timeouts_q, perf_timeouts_d;

  // Perf events: clean completions, waiting XFER cycles, timeouts
  always_comb begin
    perf_xfers_d    = perf_xfers_q;
    perf_stalls_d   = perf_stalls_q;
    perf_timeouts_d = perf_timeouts_q;
    if (xfer_complete && !bus_if.i_abort) perf_xfers_d    = sat_inc16(perf_xfers_q);
    if ((state_q == XFER) && !xfer_complete) perf_stalls_d = sat_inc16(perf_stalls_q);
    if (xfer_timeout && !bus_if.i_abort)  perf_timeouts_d = sat_inc8(perf_timeouts_q);
  end

  // Perf counter registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      perf_xfers_q    <= '0;
      perf_stalls_q   <= '0;
      perf_timeouts_q <= '0;
    end else begin
      perf_xfers_q    <= perf_xfers_d;
      perf_stalls_q   <= perf_stalls_d;
      perf_timeouts_q <= perf_timeouts_d;
    end
  end

  assign o_perf_xfers    = perf_xfers_q;
  assign o_perf_stalls   = perf_stalls_q;
  assign o_perf_timeouts = perf_timeouts_q;
`endif

endmodule

// File: tb/tb_argon_bus_sequencer.sv
// Scoreboard bench for argon_bus_sequencer: expected completions are queued when
// a request is offered and compared when o_done_valid pulses.
module tb_argon_bus_sequencer;
  import bus_seq_pkg::*;

  localparam logic [3:0] ID_REGFILE = 4'h1;
  localparam logic [3:0] ID_ALU     = 4'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  argon_bus_sequencer_if #(.TAG_W(4)) bif ();

`ifdef ARGON_BUS_SEQ_PERF_EN
  logic [15:0] perf_xfers, perf_stalls;
  logic [7:0]  perf_timeouts;
`endif

  argon_bus_sequencer #(
    .DEPTH   (4),
    .TAG_W   (4),
    .TIMEOUT (15)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus_if  (bif.slave)
`ifdef ARGON_BUS_SEQ_PERF_EN
    ,
    .o_perf_xfers    (perf_xfers),
    .o_perf_stalls   (perf_stalls),
    .o_perf_timeouts (perf_timeouts)
`endif
  );

  typedef struct packed {
    logic [3:0] tag;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] s, input logic [3:0] sc,
                       input logic [3:0] d, input logic [3:0] dc, input logic [3:0] tg);
    bif.i_req_valid   = 1'b1;
    bif.i_req_src_id  = s;
    bif.i_req_src_cmd = sc;
    bif.i_req_dst_id  = d;
    bif.i_req_dst_cmd = dc;
    bif.i_req_tag     = tg;
  endtask

  task automatic expect_done(input logic [3:0] tg, input logic err);
    exp_t e;
    e.tag = tg;
    e.err = err;
    sb.push_back(e);
  endtask

  // Completion monitor: every pulse must match the oldest expected completion
  always @(negedge clk) begin
    exp_t e;
    if (bif.o_done_valid) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_tag", 32'(bif.o_done_tag), 32'(e.tag));
        chk("done_error", 32'(bif.o_done_error), 32'(e.err));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.i_req_valid   = 1'b0;
    bif.i_req_src_id  = ID_NONE;
    bif.i_req_src_cmd = 4'h0;
    bif.i_req_dst_id  = ID_NONE;
    bif.i_req_dst_cmd = 4'h0;
    bif.i_req_tag     = 4'h0;
    bif.i_abort       = 1'b0;
    bif.i_bus_valid   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_write_id", 32'(bif.o_write_id), 32'(ID_NONE));
    chk("rst_read_id", 32'(bif.o_read_id), 32'(ID_NONE));
    chk("rst_write_cmd", 32'(bif.o_write_command), 32'h0);
    chk("rst_read_cmd", 32'(bif.o_read_command), 32'h0);
    chk("rst_done_valid", 32'(bif.o_done_valid), 32'h0);
    chk("rst_done_tag", 32'(bif.o_done_tag), 32'h0);
    chk("rst_busy", 32'(bif.o_busy), 32'h0);
    chk("rst_ready_low", 32'(bif.o_req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 32'(bif.o_req_ready), 32'h1);
    tick();

    // 1: single transfer with bus valid high
    bif.i_bus_valid = 1'b1;
    offer(ID_REGFILE, 4'd2, ID_ALU, 4'd1, 4'd3);
    expect_done(4'd3, 1'b0);
    chk("t1_ready", 32'(bif.o_req_ready), 32'h1);
    tick();
    bif.i_req_valid = 1'b0;
    tick();
    chk("t1_write_id", 32'(bif.o_write_id), 32'(ID_REGFILE));
    chk("t1_write_cmd", 32'(bif.o_write_command), 32'd2);
    chk("t1_read_id", 32'(bif.o_read_id), 32'(ID_ALU));
    chk("t1_read_cmd", 32'(bif.o_read_command), 32'd1);
    tick();
    chk("t1_done_valid", 32'(bif.o_done_valid), 32'h1);
    chk("t1_idle_write_id", 32'(bif.o_write_id), 32'(ID_NONE));
    tick();
    chk("t1_busy", 32'(bif.o_busy), 32'h0);

    // 2: four back-to-back ops, one transfer per cycle
    for (int i = 0; i < 4; i++) begin
      offer(ID_REGFILE, 4'(i), ID_ALU, 4'(i + 4), 4'(i + 4));
      expect_done(4'(i + 4), 1'b0);
      chk("t2_ready", 32'(bif.o_req_ready), 32'h1);
      tick();
      if (i > 0) begin
        chk("t2_write_cmd", 32'(bif.o_write_command), 32'(i - 1));
        chk("t2_read_cmd", 32'(bif.o_read_command), 32'(i + 3));
      end
    end
    bif.i_req_valid = 1'b0;
    tick();
    chk("t2_write_cmd_last", 32'(bif.o_write_command), 32'd3);
    tick();
    chk("t2_idle_write_id", 32'(bif.o_write_id), 32'(ID_NONE));
    tick();

    // 3: timeout with bus valid held low
    bif.i_bus_valid = 1'b0;
    offer(ID_REGFILE, 4'd6, ID_ALU, 4'd7, 4'd9);
    expect_done(4'd9, 1'b1);
    tick();
    bif.i_req_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t3_hold_write_id", 32'(bif.o_write_id), 32'(ID_REGFILE));
      tick();
    end
    chk("t3_done_valid", 32'(bif.o_done_valid), 32'h1);
    chk("t3_write_id_none", 32'(bif.o_write_id), 32'(ID_NONE));
    chk("t3_read_id_none", 32'(bif.o_read_id), 32'(ID_NONE));
    tick();

    // 4: command-only op (no destination) completes without bus valid
    offer(ID_ALU, 4'd7, ID_NONE, 4'd0, 4'd5);
    expect_done(4'd5, 1'b0);
    tick();
    bif.i_req_valid = 1'b0;
    tick();
    chk("t4_write_id", 32'(bif.o_write_id), 32'(ID_ALU));
    chk("t4_write_cmd", 32'(bif.o_write_command), 32'd7);
    chk("t4_read_id", 32'(bif.o_read_id), 32'(ID_NONE));
    tick();
    chk("t4_done_valid", 32'(bif.o_done_valid), 32'h1);
    chk("t4_idle_write_id", 32'(bif.o_write_id), 32'(ID_NONE));
    chk("t4_busy", 32'(bif.o_busy), 32'h0);
    tick();

    // 5: abort in the second cycle of the first XFER with ops queued
    offer(ID_REGFILE, 4'd1, ID_ALU, 4'd1, 4'd10);
    expect_done(4'd10, 1'b1);
    tick();
    offer(ID_REGFILE, 4'd2, ID_ALU, 4'd2, 4'd11);
    tick();
    offer(ID_REGFILE, 4'd3, ID_ALU, 4'd3, 4'd12);
    tick();
    offer(ID_REGFILE, 4'd4, ID_ALU, 4'd4, 4'd13);
    bif.i_abort = 1'b1;
    #1;
    chk("t5_ready_abort", 32'(bif.o_req_ready), 32'h0);
    tick();
    bif.i_abort     = 1'b0;
    bif.i_req_valid = 1'b0;
    chk("t5_done_valid", 32'(bif.o_done_valid), 32'h1);
    chk("t5_write_id_none", 32'(bif.o_write_id), 32'(ID_NONE));
    tick();
    chk("t5_busy", 32'(bif.o_busy), 32'h0);
    chk("t5_write_id_none2", 32'(bif.o_write_id), 32'(ID_NONE));
    tick();
    chk("t5_busy2", 32'(bif.o_busy), 32'h0);
    chk("t5_write_id_none3", 32'(bif.o_write_id), 32'(ID_NONE));
    tick();

    // 6: reset mid-XFER with two ops queued
    offer(ID_REGFILE, 4'd1, ID_ALU, 4'd1, 4'd1);
    tick();
    offer(ID_REGFILE, 4'd2, ID_ALU, 4'd2, 4'd2);
    tick();
    offer(ID_REGFILE, 4'd3, ID_ALU, 4'd3, 4'd3);
    tick();
    bif.i_req_valid = 1'b0;
    chk("t6_xfer_write_id", 32'(bif.o_write_id), 32'(ID_REGFILE));
    rst = 1'b1;
    #1;
    chk("t6_ready_in_reset", 32'(bif.o_req_ready), 32'h0);
    tick();
    chk("t6_write_id", 32'(bif.o_write_id), 32'(ID_NONE));
    chk("t6_read_id", 32'(bif.o_read_id), 32'(ID_NONE));
    chk("t6_write_cmd", 32'(bif.o_write_command), 32'h0);
    chk("t6_done_valid", 32'(bif.o_done_valid), 32'h0);
    chk("t6_done_tag", 32'(bif.o_done_tag), 32'h0);
    chk("t6_done_error", 32'(bif.o_done_error), 32'h0);
    chk("t6_busy", 32'(bif.o_busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_ready_after", 32'(bif.o_req_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_busy_after", 32'(bif.o_busy), 32'h0);
      chk("t6_write_id_after", 32'(bif.o_write_id), 32'(ID_NONE));
    end

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
